// File: rtl/fnn_pkg.sv
// Shared types and constants for the layer-serialization receive path.
package fnn_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned MAX_W  = 64;

  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_e;

  typedef logic signed [WORD_W-1:0] word_t;

  // Most-negative two's-complement value of the given width, zero-extended to MAX_W.
  function automatic logic [MAX_W-1:0] most_negative(input int unsigned width);
    logic [MAX_W-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/serial_frame_collector_if.sv
// Feeder/consumer bundle for the serial frame collector.
interface serial_frame_collector_if #(
  parameter int N_WORDS    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
);
  logic                          start_in;
  logic                          valid_in;
  logic [DATA_WIDTH-1:0]         data_in;
  logic                          ack_in;
  logic                          clear_err;
  logic [N_WORDS*DATA_WIDTH-1:0] data_out;
  logic [IDX_W-1:0]              max_idx;
  logic [DATA_WIDTH-1:0]         max_val;
  logic                          frame_valid;
  logic                          done_out;
  logic                          busy;
  logic                          err_overflow;
  logic                          err_short;

  modport master (
    output start_in, valid_in, data_in, ack_in, clear_err,
    input  data_out, max_idx, max_val, frame_valid, done_out, busy, err_overflow, err_short
  );

  modport slave (
    input  start_in, valid_in, data_in, ack_in, clear_err,
    output data_out, max_idx, max_val, frame_valid, done_out, busy, err_overflow, err_short
  );
endinterface

// File: rtl/serial_frame_collector_argmax.sv
// Registered signed running-max; ties keep the earlier (lower) index.
module argmax_tracker
  import fnn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         load_i,
  input  logic [IDX_W-1:0]             idx_i,
  input  logic signed [DATA_WIDTH-1:0] val_i,
  output logic [IDX_W-1:0]             max_idx_o,
  output logic signed [DATA_WIDTH-1:0] max_val_o
);
  localparam logic [DATA_WIDTH-1:0] MOST_NEG = DATA_WIDTH'(most_negative(DATA_WIDTH));

  logic [IDX_W-1:0]             max_idx_q;
  logic signed [DATA_WIDTH-1:0] max_val_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      max_idx_q <= '0;
      max_val_q <= '0;
    end else if (clear_i && load_i) begin
      // word 0 of a new frame loads unconditionally
      max_idx_q <= idx_i;
      max_val_q <= val_i;
    end else if (clear_i) begin
      max_idx_q <= '0;
      max_val_q <= MOST_NEG;
    end else if (load_i && (val_i > max_val_q)) begin
      max_idx_q <= idx_i;
      max_val_q <= val_i;
    end
  end

  assign max_idx_o = max_idx_q;
  assign max_val_o = max_val_q;
endmodule

// File: rtl/serial_frame_collector.sv
// Reassembles N_WORDS serial words into one parallel frame, tracks its argmax, and holds it until acked.
module serial_frame_collector
  import fnn_pkg::*;
#(
  parameter int N_WORDS    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_in,
  input  logic                          valid_in,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          ack_in,
  input  logic                          clear_err,
  output logic [N_WORDS*DATA_WIDTH-1:0] data_out,
  output logic [IDX_W-1:0]              max_idx,
  output logic [DATA_WIDTH-1:0]         max_val,
  output logic                          frame_valid,
  output logic                          done_out,
  output logic                          busy,
  output logic                          err_overflow,
  output logic                          err_short
);
  state_e           state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             frame_valid_q, done_q, busy_q, err_overflow_q, err_short_q;
  logic [DATA_WIDTH-1:0] slot_q [N_WORDS];

  logic             restart, first_word, collect_word, last_word, wr_en;
  logic             overflow_evt, short_evt;
  logic [IDX_W-1:0] wr_idx;
  logic signed [DATA_WIDTH-1:0] track_val;

  always_comb begin
    restart      = start_in && (state_q == IDLE || state_q == COLLECT ||
                                (state_q == HOLD && ack_in));
    first_word   = restart && valid_in;
    collect_word = (state_q == COLLECT) && !start_in && valid_in;
    last_word    = collect_word && (cnt_q == IDX_W'(N_WORDS - 1));
    wr_en        = first_word || collect_word;
    wr_idx       = first_word ? '0 : cnt_q;
    // anything offered while a frame is held (other than an acked restart) is lost
    overflow_evt = (state_q == HOLD) && ((valid_in && !restart) || (start_in && !ack_in));
    short_evt    = (state_q == COLLECT) && start_in;
    track_val    = $signed(data_in);
  end

  generate
    for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_q[gi] <= '0;
        end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
          slot_q[gi] <= data_in;
        end
      end
      assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q[gi];
    end
  endgenerate

  argmax_tracker #(
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_argmax (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (restart),
    .load_i    (wr_en),
    .idx_i     (wr_idx),
    .val_i     (track_val),
    .max_idx_o (max_idx),
    .max_val_o (max_val)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      frame_valid_q  <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      err_short_q    <= 1'b0;
    end else begin
      done_q         <= 1'b0;
      err_overflow_q <= overflow_evt || (err_overflow_q && !clear_err);
      err_short_q    <= short_evt || (err_short_q && !clear_err);
      if (restart) begin
        state_q       <= COLLECT;
        cnt_q         <= valid_in ? IDX_W'(1) : '0;
        frame_valid_q <= 1'b0;
        busy_q        <= 1'b1;
      end else begin
        case (state_q)
          COLLECT: begin
            if (last_word) begin
              state_q       <= HOLD;
              cnt_q         <= '0;
              frame_valid_q <= 1'b1;
              done_q        <= 1'b1;
              busy_q        <= 1'b0;
            end else if (collect_word) begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          HOLD: begin
            if (ack_in) begin
              state_q       <= IDLE;
              frame_valid_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign frame_valid  = frame_valid_q;
  assign done_out     = done_q;
  assign busy         = busy_q;
  assign err_overflow = err_overflow_q;
  assign err_short    = err_short_q;
endmodule

// File: tb/tb_serial_frame_collector.sv
// Directed bench for serial_frame_collector: frame assembly, argmax, handshake, errors and reset.
module tb_serial_frame_collector;
  import fnn_pkg::*;

  localparam int NW = 4;
  localparam int DW = 16;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_frame_collector_if #(.N_WORDS(NW), .DATA_WIDTH(DW), .IDX_W(IW)) bus ();

  serial_frame_collector #(.N_WORDS(NW), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_in     (bus.start_in),
    .valid_in     (bus.valid_in),
    .data_in      (bus.data_in),
    .ack_in       (bus.ack_in),
    .clear_err    (bus.clear_err),
    .data_out     (bus.data_out),
    .max_idx      (bus.max_idx),
    .max_val      (bus.max_val),
    .frame_valid  (bus.frame_valid),
    .done_out     (bus.done_out),
    .busy         (bus.busy),
    .err_overflow (bus.err_overflow),
    .err_short    (bus.err_short)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-16s observed=%h expected=%h ok", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic s, input logic v, input logic [DW-1:0] d,
                      input logic a, input logic c);
    bus.start_in  = s;
    bus.valid_in  = v;
    bus.data_in   = d;
    bus.ack_in    = a;
    bus.clear_err = c;
    @(posedge clk);
    #1;
    bus.start_in  = 1'b0;
    bus.valid_in  = 1'b0;
    bus.ack_in    = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  initial begin
    word_t w;
    bus.start_in = 1'b0; bus.valid_in = 1'b0; bus.data_in = '0;
    bus.ack_in = 1'b0; bus.clear_err = 1'b0;
    rst = 1'b1;
    step(0, 0, 16'h0, 0, 0);
    step(0, 0, 16'h0, 0, 0);
    rst = 1'b0;
    check("rst_data",   bus.data_out, 64'h0);
    check("rst_valid",  64'(bus.frame_valid), 64'h0);
    check("rst_busy",   64'(bus.busy), 64'h0);
    check("rst_maxval", 64'(bus.max_val), 64'h0);

    // frame 1: mixed signs
    step(1, 1, 16'h0100, 0, 0);
    check("f1_busy", 64'(bus.busy), 64'h1);
    step(0, 1, 16'hFF00, 0, 0);
    step(0, 1, 16'h0300, 0, 0);
    step(0, 1, 16'h0200, 0, 0);
    check("f1_done",   64'(bus.done_out), 64'h1);
    check("f1_valid",  64'(bus.frame_valid), 64'h1);
    check("f1_data",   bus.data_out, 64'h0200_0300_FF00_0100);
    check("f1_maxidx", 64'(bus.max_idx), 64'h2);
    check("f1_maxval", 64'(bus.max_val), 64'h0300);
    step(0, 0, 16'h0, 0, 0);
    check("f1_done_pulse", 64'(bus.done_out), 64'h0);
    check("f1_hold_valid", 64'(bus.frame_valid), 64'h1);
    step(0, 0, 16'h0, 1, 0);
    check("f1_ack_valid", 64'(bus.frame_valid), 64'h0);

    // stray valid in IDLE is ignored
    step(0, 1, 16'h1234, 0, 0);
    check("idle_busy", 64'(bus.busy), 64'h0);
    check("idle_err",  64'(bus.err_overflow), 64'h0);

    // frame 2: all negative, tie at the max
    step(1, 1, 16'hF000, 0, 0);
    step(0, 1, 16'hF800, 0, 0);
    step(0, 1, 16'hF800, 0, 0);
    step(0, 1, 16'hE000, 0, 0);
    check("f2_maxidx", 64'(bus.max_idx), 64'h1);
    check("f2_maxval", 64'(bus.max_val), 64'hF800);
    w = word_t'(bus.max_val);
    check("f2_signed", 64'(w < 0), 64'h1);
    step(0, 0, 16'h0, 1, 0);

    // frame 3: restarted after two words
    step(1, 1, 16'h0AAA, 0, 0);
    step(0, 1, 16'h0BBB, 0, 0);
    check("f3_noshort", 64'(bus.err_short), 64'h0);
    step(1, 1, 16'h0001, 0, 0);
    check("f3_short", 64'(bus.err_short), 64'h1);
    step(0, 1, 16'h0002, 0, 0);
    step(0, 1, 16'h0003, 0, 0);
    check("f3_notdone", 64'(bus.done_out), 64'h0);
    step(0, 1, 16'h0004, 0, 0);
    check("f3_done",   64'(bus.done_out), 64'h1);
    check("f3_data",   bus.data_out, 64'h0004_0003_0002_0001);
    check("f3_maxidx", 64'(bus.max_idx), 64'h3);

    // overflow while holding
    step(0, 1, 16'h7FFF, 0, 0);
    check("ovf_flag",  64'(bus.err_overflow), 64'h1);
    check("ovf_data",  bus.data_out, 64'h0004_0003_0002_0001);
    check("ovf_valid", 64'(bus.frame_valid), 64'h1);
    check("ovf_maxval", 64'(bus.max_val), 64'h0004);
    step(0, 0, 16'h0, 0, 1);
    check("clr_ovf",   64'(bus.err_overflow), 64'h0);
    check("clr_short", 64'(bus.err_short), 64'h0);

    // ack + start together: back-to-back frame, no idle bubble
    step(1, 1, 16'h0005, 1, 0);
    check("b2b_busy",  64'(bus.busy), 64'h1);
    check("b2b_valid", 64'(bus.frame_valid), 64'h0);
    check("b2b_ovf",   64'(bus.err_overflow), 64'h0);
    step(0, 1, 16'h0006, 0, 0);
    step(0, 1, 16'h0007, 0, 0);
    step(0, 1, 16'h0008, 0, 0);
    check("b2b_done",   64'(bus.done_out), 64'h1);
    check("b2b_data",   bus.data_out, 64'h0008_0007_0006_0005);
    check("b2b_maxidx", 64'(bus.max_idx), 64'h3);
    step(0, 0, 16'h0, 1, 0);

    // reset mid-frame
    step(1, 1, 16'h0001, 0, 0);
    step(0, 1, 16'h0002, 0, 0);
    step(0, 1, 16'h0003, 0, 0);
    rst = 1'b1;
    step(0, 0, 16'h0, 0, 0);
    rst = 1'b0;
    check("mrst_data",   bus.data_out, 64'h0);
    check("mrst_busy",   64'(bus.busy), 64'h0);
    check("mrst_maxidx", 64'(bus.max_idx), 64'h0);
    check("mrst_maxval", 64'(bus.max_val), 64'h0);
    step(0, 1, 16'h0099, 0, 0);
    check("mrst_idle", 64'(bus.done_out), 64'h0);
    step(1, 1, 16'h0010, 0, 0);
    step(0, 1, 16'h0050, 0, 0);
    step(0, 1, 16'h0020, 0, 0);
    step(0, 1, 16'h0050, 0, 0);
    check("f6_done",   64'(bus.done_out), 64'h1);
    check("f6_data",   bus.data_out, 64'h0050_0020_0050_0010);
    check("f6_maxidx", 64'(bus.max_idx), 64'h1);
    check("f6_maxval", 64'(bus.max_val), 64'h0050);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_frame_collector.md
Name: serial_frame_collector

Overview:
- Receive end of the layer serialization stream: accepts one DATA_WIDTH word per strobe from a feeder bus and reassembles a full layer vector of N_WORDS words into one parallel register.
- While collecting, tracks the signed argmax of the frame.
- Presents the completed vector with a valid/ack handshake, for consumers that need a whole layer at once (output classification, debug capture, or the next parallel stage).

Parameters:
- N_WORDS, 4: words per frame (neuron count of the producing layer); must be ≥ 2.
- DATA_WIDTH, 16: word width; words are two's-complement fixed point.
- IDX_W, 4: width of max_idx; must satisfy 2**IDX_W ≥ N_WORDS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start_in  in  1  one-cycle frame-start pulse (the upstream done pulse).
- valid_in  in  1  word strobe; data_in is sampled when high.
- data_in  in  DATA_WIDTH  serialized word.
- ack_in  in  1  consumer has taken the frame.
- clear_err  in  1  clears the sticky error flags.
- data_out  out  N_WORDS*DATA_WIDTH  assembled frame; word k is at bits [k*DATA_WIDTH +: DATA_WIDTH].
- max_idx  out  IDX_W  index of the largest signed word.
- max_val  out  DATA_WIDTH  value of that word.
- frame_valid  out  1  level; data_out, max_idx and max_val are valid.
- done_out  out  1  one-cycle pulse when a frame completes.
- busy  out  1  high in COLLECT.
- err_overflow  out  1  sticky; a word or start was dropped in HOLD.
- err_short  out  1  sticky; a frame was restarted before it completed.

Behaviour:
- Reset, synchronous: every output is 0, the word counter is 0, and the state is IDLE. Reset mid-frame discards the partial frame.
- States: IDLE, COLLECT, HOLD. All outputs are registered.
- IDLE:
  - start_in → COLLECT, with counter=0, max_val=most-negative value and max_idx=0.
  - If valid_in is high in the same cycle as start_in, that word is captured as word 0 and the counter becomes 1.
  - valid_in without start_in in IDLE is ignored; no error is raised.
- COLLECT:
  - Each valid_in writes data_in to slot[counter] and increments the counter.
  - Argmax update: if data_in > max_val (signed, strict), max_val=data_in and max_idx=counter. Ties keep the lower index. Word 0 always loads.
  - When the word at counter==N_WORDS-1 is written: next state HOLD; frame_valid=1 and done_out=1 on the following cycle. Latency from the last valid word to done_out is 1 cycle.
  - start_in in COLLECT: err_short is set and the collection restarts exactly as from IDLE, including same-cycle valid_in capture.
- HOLD:
  - data_out, max_idx and max_val are frozen. frame_valid stays high; done_out is high only on the first HOLD cycle.
  - ack_in: frame_valid drops next cycle and the state returns to IDLE. If start_in is also high that cycle, go directly to COLLECT (back-to-back frames, no bubble), again with same-cycle valid_in capture.
  - valid_in, or start_in without ack_in: the input is dropped, err_overflow is set and the frame is kept.
- data_out slots are written in place. Contents are only guaranteed while frame_valid=1; slots beyond the current count hold stale data.
- Errors: err_overflow and err_short are sticky until clear_err or rst. If clear_err and a new error event occur in the same cycle, the error wins (flag = 1).
- busy = (state == COLLECT).

Decomposition:
- fnn_pkg holds:
  - the state enum typedef (IDLE/COLLECT/HOLD);
  - a signed-word typedef parameterised by DATA_WIDTH;
  - a most-negative-value constant function.
- One sub-module, argmax_tracker: a registered signed running-max unit.
  - Inputs: clear, load enable, index, value.
  - Outputs: max_idx, max_val.
  - The collector instantiates it once.

Test Plan:
- Reset, then start_in with 4 valid words 0x0100, 0xFF00, 0x0300, 0x0200 on consecutive cycles → done_out pulses one cycle after the 4th word; data_out=0x0200_0300_FF00_0100; max_idx=2; max_val=0x0300; frame_valid held until ack_in.
- All-negative frame 0xF000, 0xF800, 0xF800, 0xE000 → max_idx=1 (tie resolves to the lower index); max_val=0xF800.
- start_in after 2 words, then 4 words 1, 2, 3, 4 → err_short=1; data_out=0x0004_0003_0002_0001; max_idx=3.
- In HOLD, valid_in=1 with 0x7FFF and no ack → err_overflow=1; data_out unchanged; then clear_err → flag returns to 0.
- ack_in and start_in in the same cycle with word 0x0005 → no idle bubble; the new frame's word 0 = 0x0005; the next done_out comes one cycle after the 4th word.
- rst asserted after 3 words → all outputs 0 next cycle; a following full frame completes normally with correct argmax.
